sync_fifo: RTL and testbench

- Single-clock synchronous first-in/first-out buffer, FIFO_WIDTH bits wide and FIFO_DEPTH entries deep.
- A producer pushes data via din_a/wen_a and a consumer pops it via ren_b/dout_b.
- Status flags full and empty gate both sides.
- Used as a general-purpose rate-smoothing buffer between two blocks in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_if.sv | 23 ++
 rtl/sync_fifo_mem.sv | 30 +++
 rtl/sync_fifo.sv | 62 ++++++
 tb/tb_sync_fifo.sv | 124 ++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and width helper for the synchronous FIFO
package sync_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 512;
  localparam int ADDR_W         = clog2(DEF_FIFO_DEPTH);
  localparam int CNT_W          = ADDR_W + 1;

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - producer/consumer handshake bundle for the synchronous FIFO
interface sync_fifo_if #(
  parameter int FIFO_WIDTH = 16
) ();

  logic [FIFO_WIDTH-1:0] din_a;
  logic                  wen_a;
  logic                  ren_b;
  logic [FIFO_WIDTH-1:0] dout_b;
  logic                  full;
  logic                  empty;

  modport master (
    output din_a, wen_a, ren_b,
    input  dout_b, full, empty
  );

  modport slave (
    input  din_a, wen_a, ren_b,
    output dout_b, full, empty
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - simple dual-port RAM, one write port and one registered read port
module sync_fifo_mem #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read/write returns the old word (read frees the slot being written).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO: pointers, occupancy count, flags and accept logic
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512
) (
  input  logic     clk_a,
  input  logic     rst,
  sync_fifo_if.slave fifo
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [FIFO_WIDTH-1:0] rd_data;

  assign fifo.full   = (count == CW'(FIFO_DEPTH));
  assign fifo.empty  = (count == '0);
  assign fifo.dout_b = rd_data;

  // A full FIFO still accepts a write when a read drains a slot in the same cycle.
  assign rd_acc = fifo.ren_b && !fifo.empty;
  assign wr_acc = fifo.wen_a && (!fifo.full || rd_acc);

  always_ff @(posedge clk_a or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (AW)
  ) u_mem (
    .clk   (clk_a),
    .rst_n (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (fifo.din_a),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .q     (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized bench for sync_fifo against a queue reference model
module tb_sync_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 512;

  logic clk_a;
  logic rst;

  sync_fifo_if #(.FIFO_WIDTH(W)) bus ();

  sync_fifo #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_a (clk_a),
    .rst   (rst),
    .fifo  (bus)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  int           n_cmp;
  int           n_err;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_dout;
  logic [W-1:0] vals[DEPTH + 1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},  32'(bus.dout_b), 32'(exp_dout));
    check({tag, ".full"},  32'(bus.full),   32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty),  32'(model_q.size() == 0));
  endtask

  // Called at a falling edge: drive, clock, update the model, check at next falling edge.
  task automatic step(input string tag, input logic wen, input logic [W-1:0] din, input logic ren);
    bit rd;
    bit wr;
    bus.wen_a = wen;
    bus.din_a = din;
    bus.ren_b = ren;
    rd = ren && (model_q.size() > 0);
    wr = wen && ((model_q.size() < DEPTH) || rd);
    @(posedge clk_a);
    if (rd) exp_dout = model_q.pop_front();
    if (wr) model_q.push_back(din);
    @(negedge clk_a);
    check_outputs(tag);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_dout  = '0;
    rst       = 1'b0;
    bus.wen_a = 1'b0;
    bus.ren_b = 1'b0;
    bus.din_a = '0;
    for (int i = 0; i <= DEPTH; i++) vals[i] = W'($urandom);

    repeat (2) @(negedge clk_a);
    check_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, vals[i], 1'b0);
    check("fill.full_reached", 32'(bus.full), 32'd1);

    step("first_read", 1'b0, '0, 1'b1);
    check("first_read.v0", 32'(bus.dout_b), 32'(vals[0]));
    step("refill", 1'b1, vals[DEPTH], 1'b0);

    for (int i = 0; i < 10; i++) step("write_when_full", 1'b1, W'($urandom), 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, '0, 1'b1);
      check("drain.order", 32'(bus.dout_b), 32'(vals[i + 1]));
    end

    for (int i = 0; i < 10; i++) step("read_when_empty", 1'b0, '0, 1'b1);
    check("empty_hold.v512", 32'(bus.dout_b), 32'(vals[DEPTH]));

    step("both_when_empty", 1'b1, 16'h1234, 1'b1);
    step("no_bypass_read", 1'b0, '0, 1'b1);

    for (int i = 0; i < 100; i++) step("pre100", 1'b1, W'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) step("simul", 1'b1, W'($urandom), 1'b1);

    for (int e = 0; e < 4; e++) begin
      int pw;
      int pr;
      pw = (e % 2 == 0) ? 85 : 15;
      pr = (e % 2 == 0) ? 20 : 85;
      for (int i = 0; i < 1000; i++)
        step("random", ($urandom_range(0, 99) < pw), W'($urandom), ($urandom_range(0, 99) < pr));
    end

    for (int i = 0; i < 20; i++) step("pre_reset", 1'b1, W'($urandom), (i % 3 == 0));
    bus.wen_a = 1'b0;
    bus.ren_b = 1'b0;
    @(posedge clk_a);
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    exp_dout = '0;
    check_outputs("async_reset");
    @(negedge clk_a);
    rst = 1'b1;
    for (int i = 0; i < 200; i++)
      step("post_reset", ($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 50));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
